fcp_tx_arbiter: RTL and testbench

- Frame-level round-robin arbiter on the transmit side of the FCP channel interface.
- Watches per-channel transmit requests and drives the interface's `outport_addr` select.
- Gates the platform-to-channel `out_dst_rdy` and the channel-to-platform stream so exactly one channel owns the platform TX port for a whole frame.
- Sits between the channel interface's muxed `out_*` stream and the ethernet platform TX port.

---
 rtl/fcp_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_fcp_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fcp_tx_arbiter.sv
// Frame-level round-robin arbiter between the FCP channel mux and the platform TX port.
// Optional stall-abort logic is built when ARB_TIMEOUT_EN is defined.
module fcp_tx_arbiter #(
   parameter logic [15:0] CH_MASK        = 16'h0006,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ch_src_rdy,
   input  logic [15:0] ch_sof,
   input  logic        mux_sof,
   input  logic        mux_eof,
   input  logic        mux_src_rdy,
   input  logic [7:0]  mux_data,
   output logic        mux_dst_rdy,
   output logic [3:0]  outport_addr,
   output logic        tx_sof,
   output logic        tx_eof,
   output logic        tx_src_rdy,
   output logic [7:0]  tx_data,
   input  logic        tx_dst_rdy,
   output logic        busy,
   output logic        frame_done,
   output logic        sof_err,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      XFER
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  last_grant;
   logic [3:0]  winner;
   logic [15:0] req;
   logic        in_xfer;
   logic        first_beat;
   logic        beat;
   logic        eof_beat;
   logic        timeout_hit;

   assign req      = ch_src_rdy & ch_sof & CH_MASK;
   assign in_xfer  = (state == XFER);
   assign beat     = in_xfer & mux_src_rdy & tx_dst_rdy;
   assign eof_beat = beat & mux_eof;

   // Rotating priority: the search starts just past the previous winner.
   always_comb begin
      logic [3:0] idx;
      logic       found;
      winner = last_grant;
      found  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= 16; i++) begin
         idx = last_grant + 4'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         outport_addr <= 4'h0;
         last_grant   <= 4'hF;
         first_beat   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && req != 16'h0000) begin
            outport_addr <= winner;
         end
         if (eof_beat || timeout_hit) begin
            last_grant <= outport_addr;
         end
         if (state == SETTLE) begin
            first_beat <= 1'b1;
         end else if (beat) begin
            first_beat <= 1'b0;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] stall_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive beatless cycle of a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!in_xfer || beat) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign timeout_hit = in_xfer & ~beat & (stall_cnt == CNT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next  = state;
      mux_dst_rdy = 1'b0;
      tx_sof      = 1'b0;
      tx_eof      = 1'b0;
      tx_src_rdy  = 1'b0;
      tx_data     = 8'h00;
      case (state)
         IDLE: begin
            if (req != 16'h0000) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            state_next = XFER;
         end
         XFER: begin
            mux_dst_rdy = tx_dst_rdy;
            tx_sof      = mux_sof;
            tx_eof      = mux_eof;
            tx_src_rdy  = mux_src_rdy;
            tx_data     = mux_data;
            if (eof_beat || timeout_hit) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy        = (state != IDLE);
   assign frame_done  = eof_beat;
   assign sof_err     = beat & first_beat & ~mux_sof;
   assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_fcp_tx_arbiter.sv
// Directed bench for fcp_tx_arbiter: per-cycle vector table plus reset and timeout sequences.
// The timeout sequence is compiled only when ARB_TIMEOUT_EN is defined.
module tb_fcp_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ch_src_rdy;
   logic [15:0] ch_sof;
   logic        mux_sof;
   logic        mux_eof;
   logic        mux_src_rdy;
   logic [7:0]  mux_data;
   logic        mux_dst_rdy;
   logic [3:0]  outport_addr;
   logic        tx_sof;
   logic        tx_eof;
   logic        tx_src_rdy;
   logic [7:0]  tx_data;
   logic        tx_dst_rdy;
   logic        busy;
   logic        frame_done;
   logic        sof_err;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   fcp_tx_arbiter #(
      .CH_MASK(16'h0006),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ch_src_rdy(ch_src_rdy),
      .ch_sof(ch_sof),
      .mux_sof(mux_sof),
      .mux_eof(mux_eof),
      .mux_src_rdy(mux_src_rdy),
      .mux_data(mux_data),
      .mux_dst_rdy(mux_dst_rdy),
      .outport_addr(outport_addr),
      .tx_sof(tx_sof),
      .tx_eof(tx_eof),
      .tx_src_rdy(tx_src_rdy),
      .tx_data(tx_data),
      .tx_dst_rdy(tx_dst_rdy),
      .busy(busy),
      .frame_done(frame_done),
      .sof_err(sof_err),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] csr;
      logic [15:0] csof;
      logic        ms;
      logic        me;
      logic        mv;
      logic [7:0]  md;
      logic        dr;
      logic        e_mdr;
      logic [3:0]  e_addr;
      logic        e_tv;
      logic        e_ts;
      logic        e_te;
      logic [7:0]  e_td;
      logic        e_busy;
      logic        e_fd;
      logic        e_se;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [15:0] csr, input logic [15:0] csof,
                      input logic ms, input logic me, input logic mv,
                      input logic [7:0] md, input logic dr,
                      input logic e_mdr, input logic [3:0] e_addr,
                      input logic e_tv, input logic e_ts, input logic e_te,
                      input logic [7:0] e_td, input logic e_busy,
                      input logic e_fd, input logic e_se);
      vec_t v;
      v.csr = csr; v.csof = csof; v.ms = ms; v.me = me; v.mv = mv; v.md = md; v.dr = dr;
      v.e_mdr = e_mdr; v.e_addr = e_addr; v.e_tv = e_tv; v.e_ts = e_ts; v.e_te = e_te;
      v.e_td = e_td; v.e_busy = e_busy; v.e_fd = e_fd; v.e_se = e_se;
      vq.push_back(v);
   endtask

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] csr, input logic [15:0] csof,
                                 input logic ms, input logic me, input logic mv,
                                 input logic [7:0] md, input logic dr);
      ch_src_rdy  = csr;
      ch_sof      = csof;
      mux_sof     = ms;
      mux_eof     = me;
      mux_src_rdy = mv;
      mux_data    = md;
      tx_dst_rdy  = dr;
   endtask

   task automatic check_vector(input int n, input vec_t v);
      check_output($sformatf("v%0d mux_dst_rdy", n), 16'(mux_dst_rdy), 16'(v.e_mdr));
      check_output($sformatf("v%0d outport_addr", n), 16'(outport_addr), 16'(v.e_addr));
      check_output($sformatf("v%0d tx_src_rdy", n), 16'(tx_src_rdy), 16'(v.e_tv));
      check_output($sformatf("v%0d tx_sof", n), 16'(tx_sof), 16'(v.e_ts));
      check_output($sformatf("v%0d tx_eof", n), 16'(tx_eof), 16'(v.e_te));
      check_output($sformatf("v%0d tx_data", n), 16'(tx_data), 16'(v.e_td));
      check_output($sformatf("v%0d busy", n), 16'(busy), 16'(v.e_busy));
      check_output($sformatf("v%0d frame_done", n), 16'(frame_done), 16'(v.e_fd));
      check_output($sformatf("v%0d sof_err", n), 16'(sof_err), 16'(v.e_se));
      check_output($sformatf("v%0d timeout_err", n), 16'(timeout_err), 16'd0);
   endtask

   initial begin
      // Columns: csr csof ms me mv md dr | mdr addr tv ts te td busy fd se
      // ch1 four-byte frame straight out of reset
      add(16'h0002, 16'h0002, 0, 0, 0, 8'h00, 1,  0, 4'd0, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0002, 16'h0002, 1, 0, 1, 8'h55, 1,  0, 4'd1, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0000, 16'h0000, 1, 0, 1, 8'hA0, 1,  1, 4'd1, 1, 1, 0, 8'hA0, 1, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 1, 8'hA1, 1,  1, 4'd1, 1, 0, 0, 8'hA1, 1, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 1, 8'hA2, 1,  1, 4'd1, 1, 0, 0, 8'hA2, 1, 0, 0);
      add(16'h0000, 16'h0000, 0, 1, 1, 8'hA3, 1,  1, 4'd1, 1, 0, 1, 8'hA3, 1, 1, 0);
      add(16'h0000, 16'h0000, 0, 1, 1, 8'h77, 1,  0, 4'd1, 0, 0, 0, 8'h00, 0, 0, 0);
      // ch1+ch2 requesting: ch2 wins, frame under backpressure 1,0,0,1
      add(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0006, 16'h0006, 1, 0, 1, 8'hB0, 1,  1, 4'd2, 1, 1, 0, 8'hB0, 1, 0, 0);
      add(16'h0006, 16'h0006, 0, 1, 1, 8'hB1, 0,  0, 4'd2, 1, 0, 1, 8'hB1, 1, 0, 0);
      add(16'h0006, 16'h0006, 0, 1, 1, 8'hB1, 0,  0, 4'd2, 1, 0, 1, 8'hB1, 1, 0, 0);
      add(16'h0006, 16'h0006, 0, 1, 1, 8'hB1, 1,  1, 4'd2, 1, 0, 1, 8'hB1, 1, 1, 0);
      // back to ch1, then ch2 whose first beat lacks sof
      add(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0006, 16'h0006, 1, 0, 1, 8'hC0, 1,  1, 4'd1, 1, 1, 0, 8'hC0, 1, 0, 0);
      add(16'h0006, 16'h0006, 0, 1, 1, 8'hC1, 1,  1, 4'd1, 1, 0, 1, 8'hC1, 1, 1, 0);
      add(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 1, 8'hD0, 1,  1, 4'd2, 1, 0, 0, 8'hD0, 1, 0, 1);
      add(16'h0000, 16'h0000, 0, 1, 1, 8'hD1, 1,  1, 4'd2, 1, 0, 1, 8'hD1, 1, 1, 0);
      // masked ch3 and sof-less ch1 must not start a grant
      add(16'h0008, 16'h0008, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0008, 16'h0008, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0002, 16'h0000, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 0, 0, 0);
      // ch1 alongside masked ch3: one-byte frame, then ch1 re-granted alone
      add(16'h000A, 16'h000A, 0, 0, 0, 8'h00, 1,  0, 4'd2, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0000, 16'h0000, 1, 1, 1, 8'hE5, 1,  1, 4'd1, 1, 1, 1, 8'hE5, 1, 1, 0);
      add(16'h0002, 16'h0002, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 0, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1,  1, 4'd1, 0, 0, 0, 8'h00, 1, 0, 0);
      add(16'h0000, 16'h0000, 1, 1, 1, 8'hF0, 1,  1, 4'd1, 1, 1, 1, 8'hF0, 1, 1, 0);
      add(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1,  0, 4'd1, 0, 0, 0, 8'h00, 0, 0, 0);

      // Reset held with ch1 requesting and the mux presenting data
      rst_n = 1'b0;
      apply_stimulus(16'h0002, 16'h0002, 1, 0, 1, 8'h99, 1);
      repeat (3) @(negedge clk);
      #1;
      check_output("reset outport_addr", 16'(outport_addr), 16'd0);
      check_output("reset tx_src_rdy", 16'(tx_src_rdy), 16'd0);
      check_output("reset busy", 16'(busy), 16'd0);
      check_output("reset mux_dst_rdy", 16'(mux_dst_rdy), 16'd0);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         apply_stimulus(vq[i].csr, vq[i].csof, vq[i].ms, vq[i].me, vq[i].mv, vq[i].md, vq[i].dr);
         #1;
         check_vector(i, vq[i]);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a ch2 frame
      apply_stimulus(16'h0004, 16'h0004, 0, 0, 0, 8'h00, 1);
      @(negedge clk);
      @(negedge clk);
      apply_stimulus(16'h0000, 16'h0000, 1, 0, 1, 8'h11, 1);
      #1;
      check_output("midrst pre tx_src_rdy", 16'(tx_src_rdy), 16'd1);
      check_output("midrst pre outport_addr", 16'(outport_addr), 16'd2);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("midrst mux_dst_rdy", 16'(mux_dst_rdy), 16'd0);
      check_output("midrst tx_src_rdy", 16'(tx_src_rdy), 16'd0);
      check_output("midrst tx_data", 16'(tx_data), 16'd0);
      check_output("midrst busy", 16'(busy), 16'd0);
      check_output("midrst outport_addr", 16'(outport_addr), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1);
      #1;
      check_output("postrst idle busy", 16'(busy), 16'd0);
      @(negedge clk);
      #1;
      check_output("postrst grant ch1", 16'(outport_addr), 16'd1);
      check_output("postrst settle busy", 16'(busy), 16'd1);
      @(negedge clk);
      apply_stimulus(16'h0000, 16'h0000, 1, 1, 1, 8'h3C, 1);
      #1;
      check_output("postrst frame_done", 16'(frame_done), 16'd1);
      check_output("postrst tx_data", 16'(tx_data), 16'h3C);
      @(negedge clk);
      apply_stimulus(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1);
      #1;
      check_output("postrst back idle", 16'(busy), 16'd0);

`ifdef ARB_TIMEOUT_EN
      // ch1 stalls after its sof beat; the abort hands the port to ch2
      @(negedge clk);
      apply_stimulus(16'h0002, 16'h0002, 0, 0, 0, 8'h00, 1);
      @(negedge clk);
      #1;
      check_output("tmo grant ch1", 16'(outport_addr), 16'd1);
      @(negedge clk);
      apply_stimulus(16'h0006, 16'h0006, 1, 0, 1, 8'h21, 1);
      #1;
      check_output("tmo sof beat", 16'(tx_src_rdy), 16'd1);
      check_output("tmo at beat", 16'(timeout_err), 16'd0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         apply_stimulus(16'h0006, 16'h0006, 0, 0, 0, 8'h00, 1);
         #1;
         check_output($sformatf("tmo stall %0d", i), 16'(timeout_err), (i == 16) ? 16'd1 : 16'd0);
      end
      @(negedge clk);
      #1;
      check_output("tmo idle busy", 16'(busy), 16'd0);
      check_output("tmo no eof", 16'(tx_eof), 16'd0);
      @(negedge clk);
      #1;
      check_output("tmo grant ch2", 16'(outport_addr), 16'd2);
      @(negedge clk);
      apply_stimulus(16'h0000, 16'h0000, 1, 1, 1, 8'h22, 1);
      #1;
      check_output("tmo ch2 frame_done", 16'(frame_done), 16'd1);
      @(negedge clk);
      apply_stimulus(16'h0000, 16'h0000, 0, 0, 0, 8'h00, 1);
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
